// File: rtl/bin_to_bcd_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the binary-to-BCD display path.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int NUM_DIGITS = 8;
    localparam int INT_DIGITS = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam logic [31:0] BCD_MAX = 32'h9999_9999;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adjust
// Description : Double-dabble digit correction: add 3 to a BCD digit >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);

    // Inputs are always 0..9, so the sum never wraps past 4'hF.
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_display
// Description : Sequential double-dabble converter feeding the 8-digit display.
//               Define BCD_SATURATE_EN to clamp overflowing values to 99999999.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_display
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 27,
    parameter int DIGITS   = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [IN_WIDTH-1:0]   bin_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  valid_out,
    output logic                  overflow_out
);

    localparam int                 C_CNT_W      = $clog2(IN_WIDTH + 1);
    localparam int                 C_BCD_W      = 4 * INT_DIGITS;
    localparam int                 C_OUT_W      = 4 * NUM_DIGITS;
    localparam logic [C_CNT_W-1:0] C_LAST_SHIFT = C_CNT_W'(IN_WIDTH - 1);

    bcd_state_t            r_state_q, w_state_d;
    logic [IN_WIDTH-1:0]   r_bin_q,   w_bin_d;
    logic [C_BCD_W-1:0]    r_bcd_q,   w_bcd_d;
    logic [C_CNT_W-1:0]    r_cnt_q,   w_cnt_d;
    logic [C_OUT_W-1:0]    r_out_q,   w_out_d;
    logic                  r_ovf_q,   w_ovf_d;
    logic                  r_valid_q, w_valid_d;
    logic                  r_ready_q, w_ready_d;
    logic [C_BCD_W-1:0]    w_adj;
    logic                  w_ovf;

    generate
        for (genvar g = 0; g < INT_DIGITS; g++) begin : g_adjust
            bcd_digit_adjust u_adjust (
                .i_digit (r_bcd_q[4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end
    endgenerate

    assign w_ovf = |r_bcd_q[C_BCD_W-1:C_OUT_W];

    always_comb begin
        w_state_d = r_state_q;
        w_bin_d   = r_bin_q;
        w_bcd_d   = r_bcd_q;
        w_cnt_d   = r_cnt_q;
        w_out_d   = r_out_q;
        w_ovf_d   = r_ovf_q;
        w_valid_d = 1'b0;
        w_ready_d = r_ready_q;
        case (r_state_q)
            IDLE: begin
                if (valid_in) begin
                    w_bin_d   = bin_in;
                    w_bcd_d   = '0;
                    w_cnt_d   = '0;
                    w_ready_d = 1'b0;
                    w_state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Adjusted digits and remaining binary shift as one wide word.
                {w_bcd_d, w_bin_d} = {w_adj, r_bin_q} << 1;
                w_cnt_d            = r_cnt_q + C_CNT_W'(1);
                if (r_cnt_q == C_LAST_SHIFT) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                w_ovf_d   = w_ovf;
`ifdef BCD_SATURATE_EN
                w_out_d   = w_ovf ? BCD_MAX : r_bcd_q[C_OUT_W-1:0];
`else
                w_out_d   = r_bcd_q[C_OUT_W-1:0];
`endif
                w_valid_d = 1'b1;
                w_ready_d = 1'b1;
                w_state_d = IDLE;
            end
            default: begin
                w_ready_d = 1'b1;
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state_q <= IDLE;
            r_bin_q   <= '0;
            r_bcd_q   <= '0;
            r_cnt_q   <= '0;
            r_out_q   <= '0;
            r_ovf_q   <= 1'b0;
            r_valid_q <= 1'b0;
            r_ready_q <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_bin_q   <= w_bin_d;
            r_bcd_q   <= w_bcd_d;
            r_cnt_q   <= w_cnt_d;
            r_out_q   <= w_out_d;
            r_ovf_q   <= w_ovf_d;
            r_valid_q <= w_valid_d;
            r_ready_q <= w_ready_d;
        end
    end

    assign ready_out    = r_ready_q;
    assign bcd_out      = r_out_q;
    assign valid_out    = r_valid_q;
    assign overflow_out = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_display
// Description : Scoreboard bench for bin_to_bcd_display (queue + output monitor).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_display;

    localparam int IN_WIDTH = 27;
    localparam int LAT      = IN_WIDTH + 1;
    localparam int PERIOD   = IN_WIDTH + 2;

    logic                clk_in   = 1'b0;
    logic                rst_in   = 1'b1;
    logic                valid_in = 1'b0;
    logic [IN_WIDTH-1:0] bin_in   = '0;
    logic                ready_out;
    logic [31:0]         bcd_out;
    logic                valid_out;
    logic                overflow_out;

    bin_to_bcd_display #(
        .IN_WIDTH (IN_WIDTH),
        .DIGITS   (8)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .bin_in       (bin_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .bcd_out      (bcd_out),
        .valid_out    (valid_out),
        .overflow_out (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          errors   = 0;
    int          checks   = 0;
    int          cyc      = 0;
    logic        rst_seen = 1'b0;
    logic [31:0] hold_bcd = '0;
    logic        hold_ovf = 1'b0;

    always @(posedge clk_in) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_in;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] bcd, input logic ovf);
        exp_t e;
        e.bcd = bcd;
        e.ovf = ovf;
        e.acc = 0;
        return e;
    endfunction

    // Expected result for an overflowing input whose low 8 digits are 'low'.
    function automatic exp_t ov(input logic [31:0] low);
`ifdef BCD_SATURATE_EN
        return mk(32'h9999_9999, 1'b1);
`else
        return mk(low, 1'b1);
`endif
    endfunction

    function automatic exp_t ref_model(input logic [IN_WIDTH-1:0] v);
        exp_t   e;
        longint x;
        x     = longint'(v);
        e.bcd = '0;
        for (int k = 0; k < 8; k++) begin
            e.bcd[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        e.ovf = (v > 27'd99_999_999);
`ifdef BCD_SATURATE_EN
        if (e.ovf) e.bcd = 32'h9999_9999;
`endif
        e.acc = 0;
        return e;
    endfunction

    // Monitor: pops the scoreboard on valid_out, otherwise checks outputs hold.
    initial begin : monitor
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk_in);
            ok = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (bcd_out[4*k +: 4] > 4'd9) ok = 1'b0;
            end
            checks++;
            assert (ok) else begin
                errors++;
                $display("FAIL digit_range: bcd_out=%h, required all digits <= 9", bcd_out);
            end
            if (rst_seen) begin
                sb.delete();
                hold_bcd = '0;
                hold_ovf = 1'b0;
                check("rst_bcd_out",   64'(bcd_out),      64'h0);
                check("rst_valid_out", 64'(valid_out),    64'h0);
                check("rst_overflow",  64'(overflow_out), 64'h0);
                check("rst_ready_out", 64'(ready_out),    64'h1);
            end else if (valid_out) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: valid_out=1 bcd_out=%h, expected no output", bcd_out);
                end else begin
                    e = sb.pop_front();
                    check("bcd_out",         64'(bcd_out),       64'(e.bcd));
                    check("overflow_out",    64'(overflow_out),  64'(e.ovf));
                    check("latency",         64'(cyc - e.acc),   64'(LAT));
                    check("ready_with_valid",64'(ready_out),     64'h1);
                    hold_bcd = e.bcd;
                    hold_ovf = e.ovf;
                end
            end else begin
                check("hold_bcd_out",  64'(bcd_out),      64'(hold_bcd));
                check("hold_overflow", 64'(overflow_out), 64'(hold_ovf));
            end
        end
    end

    task automatic send(input logic [IN_WIDTH-1:0] v, input exp_t e);
        int n;
        n = 0;
        while (ready_out !== 1'b1 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready_out=%b after %0d cycles, expected 1", ready_out, n);
        end
        bin_in   = v;
        valid_in = 1'b1;
        e.acc    = cyc + 1;
        sb.push_back(e);
        @(negedge clk_in);
        valid_in = 1'b0;
        bin_in   = IN_WIDTH'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin : stimulus
        exp_t e;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;

        send(27'd0, mk(32'h0000_0000, 1'b0));
        drain();

        // Second result must not disturb the first until its own valid_out.
        send(27'd12_345_678, mk(32'h1234_5678, 1'b0));
        send(27'd99_999_999, mk(32'h9999_9999, 1'b0));
        drain();

        send(27'd100_000_123, ov(32'h0000_0123));
        send(27'd100_000_000, ov(32'h0000_0000));
        send(27'd134_217_727, ov(32'h3421_7727));
        send(27'd9,           mk(32'h0000_0009, 1'b0));
        send(27'd10,          mk(32'h0000_0010, 1'b0));
        drain();

        // Held valid_in with bin_in changing every cycle.
        valid_in = 1'b1;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            bin_in = IN_WIDTH'(5000 + 13 * i);
            check("stream_ready", 64'(ready_out), 64'((i % PERIOD) == 0));
            if ((i % PERIOD) == 0) begin
                e     = ref_model(bin_in);
                e.acc = cyc + 1;
                sb.push_back(e);
            end
            @(negedge clk_in);
        end
        valid_in = 1'b0;
        drain();

        // Reset ten cycles into a conversion drops it entirely.
        send(27'd555, mk(32'h0000_0555, 1'b0));
        repeat (9) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (40) @(negedge clk_in);
        send(27'd555, mk(32'h0000_0555, 1'b0));
        drain();

        // Reset together with valid_in: no transfer.
        rst_in   = 1'b1;
        valid_in = 1'b1;
        bin_in   = 27'd777;
        @(negedge clk_in);
        rst_in   = 1'b0;
        valid_in = 1'b0;
        @(negedge clk_in);
        check("rst_valid_no_accept", 64'(ready_out), 64'h1);
        repeat (35) @(negedge clk_in);

        for (int v = 0; v < 200; v++) begin
            send(IN_WIDTH'(v), ref_model(IN_WIDTH'(v)));
        end
        for (int r = 0; r < 200; r++) begin
            bin_in = IN_WIDTH'($urandom);
            send(bin_in, ref_model(bin_in));
        end
        drain();
        repeat (5) @(negedge clk_in);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion before 5000000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
